// File: rtl/dcache_pkg.sv
// Shared dcache definitions: write-buffer geometry, entry layout, drain states
// and the byte-lane merge used by store coalescing.
package dcache_pkg;

    localparam int WB_DEPTH   = 4;
    localparam int WORD_OFF_W = 2;
    localparam int LINE_OFF_W = 5;
    localparam int WB_ADDR_W  = 32;
    localparam int WB_DATA_W  = 32;
    localparam int WB_BE_W    = WB_DATA_W / 8;

    typedef struct packed {
        logic [WB_ADDR_W-1:WORD_OFF_W] addr;
        logic [WB_DATA_W-1:0]          data;
        logic [WB_BE_W-1:0]            byte_en;
    } wb_entry_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_BUSY = 1'b1
    } drain_state_e;

    // Overwrite only the byte lanes selected by be.
    function automatic logic [WB_DATA_W-1:0] merge_bytes(
        input logic [WB_DATA_W-1:0] old_data,
        input logic [WB_DATA_W-1:0] new_data,
        input logic [WB_BE_W-1:0]   be
    );
        logic [WB_DATA_W-1:0] r;
        r = old_data;
        for (int b = 0; b < WB_BE_W; b++) begin
            if (be[b]) begin
                r[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for the write buffer: pointers, occupancy, valid bits,
// plus an in-place merge port that targets the youngest entry.
module wb_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int LINE_W = WB_ADDR_W - LINE_OFF_W
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push_i,
    input  logic                              pop_i,
    input  logic                              merge_i,
    input  logic [WB_ADDR_W-1:WORD_OFF_W]     push_addr_i,
    input  logic [WB_DATA_W-1:0]              push_data_i,
    input  logic [WB_BE_W-1:0]                push_be_i,
    output logic [CNT_W-1:0]                  count_o,
    output logic [WB_ADDR_W-1:WORD_OFF_W]     head_addr_o,
    output logic [WB_DATA_W-1:0]              head_data_o,
    output logic [WB_BE_W-1:0]                head_be_o,
    output logic [WB_ADDR_W-1:WORD_OFF_W]     young_addr_o,
    output logic                              young_is_head_o,
    output logic [DEPTH-1:0]                  valid_o,
    output logic [DEPTH-1:0][LINE_W-1:0]      line_o
);

    wb_entry_t          entries_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   young_ptr;
    wb_entry_t          push_entry;
    wb_entry_t          merged_entry;

    assign young_ptr = wr_ptr_q - PTR_W'(1);

    always_comb begin
        push_entry         = '0;
        push_entry.addr    = push_addr_i;
        push_entry.data    = push_data_i;
        push_entry.byte_en = push_be_i;

        merged_entry         = entries_q[young_ptr];
        merged_entry.data    = merge_bytes(entries_q[young_ptr].data, push_data_i, push_be_i);
        merged_entry.byte_en = entries_q[young_ptr].byte_en | push_be_i;

        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            // Merge never targets a slot being popped or allocated this cycle.
            if (push_i) begin
                entries_q[wr_ptr_q] <= push_entry;
                valid_q[wr_ptr_q]   <= 1'b1;
            end
            if (merge_i) begin
                entries_q[young_ptr] <= merged_entry;
            end
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o         = count_q;
    assign head_addr_o     = entries_q[rd_ptr_q].addr;
    assign head_data_o     = entries_q[rd_ptr_q].data;
    assign head_be_o       = entries_q[rd_ptr_q].byte_en;
    assign young_addr_o    = entries_q[young_ptr].addr;
    assign young_is_head_o = (young_ptr == rd_ptr_q);
    assign valid_o         = valid_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
        assign line_o[gi] = entries_q[gi].addr[WB_ADDR_W-1:LINE_OFF_W];
    end

endmodule

// File: rtl/write_buffer.sv
// Posted write buffer: FIFO of write-through stores drained by req/ack, with a
// line-granular probe for pending stores. Store coalescing enabled by WB_MERGE_EN.
module write_buffer
    import dcache_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_req_in,
    input  logic [ADDR_W-1:0]   wb_addr_in,
    input  logic [DATA_W-1:0]   wb_data_in,
    input  logic [DATA_W/8-1:0] wb_byte_en_in,
    output logic                wb_full_out,
    output logic                wb_empty_out,
    input  logic [ADDR_W-1:0]   wb_probe_addr_in,
    output logic                wb_probe_hit_out,
    output logic                wb_mem_write_req_out,
    output logic [ADDR_W-1:0]   wb_mem_addr_out,
    output logic [DATA_W-1:0]   wb_mem_data_out,
    output logic [DATA_W/8-1:0] wb_mem_byte_en_out,
    input  logic                wb_mem_ack_in
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LINE_W = ADDR_W - LINE_OFF_W;

    drain_state_e               state_q, state_d;
    logic [CNT_W-1:0]           count;
    logic [CNT_W-1:0]           count_d;
    logic [ADDR_W-1:WORD_OFF_W] head_addr;
    logic [DATA_W-1:0]          head_data;
    logic [DATA_W/8-1:0]        head_be;
    logic [ADDR_W-1:WORD_OFF_W] young_addr;
    logic                       young_is_head;
    logic [DEPTH-1:0]           valid;
    logic [DEPTH-1:0][LINE_W-1:0] lines;
    logic [DEPTH-1:0]           probe_match;
    logic                       full;
    logic                       busy;
    logic                       push;
    logic                       pop;
    logic                       merge;

    assign full = (count == CNT_W'(DEPTH));
    assign busy = (state_q == D_BUSY);
    assign pop  = busy && wb_mem_ack_in;

`ifdef WB_MERGE_EN
    // The head is frozen while being offered to the arbiter, so it never absorbs a merge.
    assign merge = wb_req_in && (count != '0) &&
                   (young_addr == wb_addr_in[ADDR_W-1:WORD_OFF_W]) &&
                   !(busy && young_is_head);
`else
    logic unused_merge;
    assign merge        = 1'b0;
    assign unused_merge = ^{young_addr, young_is_head};
`endif

    assign push    = wb_req_in && !full && !merge;
    assign count_d = count + CNT_W'(push) - CNT_W'(pop);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_fifo (
        .clk             (clk),
        .rst_n           (rst_n),
        .push_i          (push),
        .pop_i           (pop),
        .merge_i         (merge),
        .push_addr_i     (wb_addr_in[ADDR_W-1:WORD_OFF_W]),
        .push_data_i     (wb_data_in),
        .push_be_i       (wb_byte_en_in),
        .count_o         (count),
        .head_addr_o     (head_addr),
        .head_data_o     (head_data),
        .head_be_o       (head_be),
        .young_addr_o    (young_addr),
        .young_is_head_o (young_is_head),
        .valid_o         (valid),
        .line_o          (lines)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Looking at count_d lets the request rise the cycle right after the push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE: if (count_d != '0) state_d = D_BUSY;
            D_BUSY: if (pop && (count_d == '0)) state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    assign wb_full_out          = full;
    assign wb_empty_out         = (count == '0) && (state_q == D_IDLE);
    assign wb_mem_write_req_out = busy;
    assign wb_mem_addr_out      = busy ? {head_addr, {WORD_OFF_W{1'b0}}} : '0;
    assign wb_mem_data_out      = busy ? head_data : '0;
    assign wb_mem_byte_en_out   = busy ? head_be : '0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_probe
        assign probe_match[gi] = valid[gi] &&
                                 (lines[gi] == wb_probe_addr_in[ADDR_W-1:LINE_OFF_W]);
    end
    assign wb_probe_hit_out = |probe_match;

    logic unused_low_bits;
    assign unused_low_bits = ^{wb_addr_in[WORD_OFF_W-1:0], wb_probe_addr_in[LINE_OFF_W-1:0]};

endmodule
